piso4: RTL and testbench
========================

PISO4 -- requirements
Module: piso4

Interface
REQ-001 The block SHALL have one parameter: MSB_FIRST, default 1, 1 = shift D[3] first, 0 = shift D[0] first.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port D, input, 4 bits: the parallel word to serialize.
REQ-005 The block SHALL have port En, input, 1 bit: load request.
REQ-006 The block SHALL have port Ack, output, 1 bit: a one-cycle pulse marking word acceptance.
REQ-007 The block SHALL have port Q, output, 1 bit: the serial data bit.
REQ-008 The block SHALL have port Qv, output, 1 bit: serial bit valid.
REQ-009 The block SHALL have port Busy, output, 1 bit: high while a word is being shifted out.
REQ-010 The block SHALL have port Done, output, 1 bit: a one-cycle pulse coincident with the last serial bit.
REQ-011 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-012 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-013 In IDLE, an edge with En=1 SHALL capture D into a 4-bit shift register, clear the bit counter and enter SHIFT.
REQ-014 In IDLE, an edge with En=0 SHALL leave all state unchanged.
REQ-015 In the cycle after the accepting edge, outputs SHALL be Ack=1, Busy=1, Qv=1 and Q=first bit, giving one-cycle latency from En to the first bit.
REQ-016 Ack SHALL be high for exactly one cycle per accepted word.
REQ-017 SHIFT SHALL present one bit per cycle on Q with Qv=1, in the order set by MSB_FIRST.
REQ-018 The bit counter SHALL be 3 bits wide and count 0..N-1, where N=4 (N=5 under REQ-030).
REQ-019 Done SHALL be 1 only in the cycle carrying bit N-1, together with Qv=1.
REQ-020 The edge that ends bit N-1 SHALL return the FSM to IDLE, setting Busy=0, Qv=0 and Q=0.
REQ-021 Q SHALL be 0 whenever Qv=0.
REQ-022 En SHALL be sampled only when the state is IDLE at the edge; En in SHIFT SHALL be ignored and not queued.
REQ-023 D changes during SHIFT SHALL NOT affect the word in flight.
REQ-024 With En held at 1 continuously, words SHALL be accepted every N+1 cycles, with one idle cycle between words.
REQ-025 The counter SHALL never wrap past N-1, and a SHIFT state with counter ≥ N SHALL be unreachable.

Reset
REQ-026 A clock edge with Rst=1 SHALL force state=IDLE, shift register=0, counter=0, and Q=Qv=Ack=Busy=Done=0.
REQ-027 Rst SHALL take priority over En, including when both are 1 on the same edge.
REQ-028 Rst asserted mid-word SHALL abort the word: no further bits and no Done for it.
REQ-029 After Rst deasserts, the first En=1 edge SHALL be accepted normally.

Configuration
REQ-030 With macro PISO4_PARITY_EN defined, N SHALL be 5, the fifth bit SHALL be even parity (XOR of D[3:0] as captured), and Done SHALL coincide with the parity bit.
REQ-031 Without PISO4_PARITY_EN, N SHALL be 4, no parity logic SHALL be present, and the port list SHALL be identical in both builds.

Verification
REQ-032 A bench SHALL check: MSB_FIRST=1, D=4'b1010, one-cycle En -> Q=1,0,1,0 on 4 consecutive Qv cycles, Ack on the first, Done on the fourth, Busy high for 4 cycles.
REQ-033 A bench SHALL check: MSB_FIRST=0, D=4'b0110 -> Q=0,1,1,0, with Done on the fourth bit.
REQ-034 A bench SHALL check: D=4'b1100 accepted, then En=1 with D=4'b0011 during SHIFT -> output stays 1,1,0,0, only one Ack, and Busy drops after 4 cycles.
REQ-035 A bench SHALL check: Rst=1 on the third bit of D=4'b1111 -> all outputs 0 next cycle, no Done, and a new word after reset is serialized correctly.
REQ-036 A bench SHALL check: En held at 1, D=4'b1001 -> Ack pulses 5 cycles apart (6 with PISO4_PARITY_EN), each word 1,0,0,1.
REQ-037 A bench SHALL check, with PISO4_PARITY_EN: D=4'b0111 -> Q=0,1,1,1,1, with Done on the fifth bit.

Source files
------------

// File: rtl/piso4.sv
// 4-bit parallel-in / serial-out shifter with a one-cycle load handshake.
// Optional build macro PISO4_PARITY_EN appends an even-parity bit (5 bits per word).
module piso4 #(
  parameter int MSB_FIRST = 1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] D,
  input  logic       En,
  output logic       Ack,
  output logic       Q,
  output logic       Qv,
  output logic       Busy,
  output logic       Done
);

`ifdef PISO4_PARITY_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] sreg_q, sreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       q_q, q_d;
  logic       qv_q, qv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef PISO4_PARITY_EN
  logic       parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [3:0] w);
    return (MSB_FIRST != 0) ? w[3] : w[0];
  endfunction

  function automatic logic [3:0] shift_word(input logic [3:0] w);
    return (MSB_FIRST != 0) ? {w[2:0], 1'b0} : {1'b0, w[3:1]};
  endfunction

  // Outputs are computed from next-state values so they can be registered
  // and still show the first bit in the cycle right after acceptance.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    q_d      = 1'b0;
    qv_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef PISO4_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (En) begin
          state_d  = SHIFT;
          sreg_d   = D;
          cnt_d    = 3'd0;
          ack_d    = 1'b1;
          q_d      = head_bit(D);
          qv_d     = 1'b1;
          busy_d   = 1'b1;
`ifdef PISO4_PARITY_EN
          parity_d = ^D;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q >= LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          sreg_d = shift_word(sreg_q);
          qv_d   = 1'b1;
          busy_d = 1'b1;
          done_d = (cnt_d == LAST_IDX);
`ifdef PISO4_PARITY_EN
          q_d    = (cnt_d == 3'd4) ? parity_q : head_bit(sreg_d);
`else
          q_d    = head_bit(sreg_d);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      sreg_q   <= 4'd0;
      cnt_q    <= 3'd0;
      ack_q    <= 1'b0;
      q_q      <= 1'b0;
      qv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO4_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      q_q      <= q_d;
      qv_q     <= qv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PISO4_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign Ack  = ack_q;
  assign Q    = q_q;
  assign Qv   = qv_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_piso4.sv
// Scoreboard bench for piso4: one MSB-first and one LSB-first instance share stimulus.
module tb_piso4;

`ifdef PISO4_PARITY_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  typedef struct packed {
    logic q;
    logic ack;
    logic done;
  } exp_t;

  logic       Clk, Rst, En;
  logic [3:0] D;
  logic       ack_m, q_m, qv_m, busy_m, done_m;
  logic       ack_l, q_l, qv_l, busy_l, done_l;

  exp_t exp_m[$];
  exp_t exp_l[$];
  int   ack_cyc_m[$];
  int   ack_cyc_l[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  piso4 #(.MSB_FIRST(1)) dut_m (
    .Clk(Clk), .Rst(Rst), .D(D), .En(En),
    .Ack(ack_m), .Q(q_m), .Qv(qv_m), .Busy(busy_m), .Done(done_m)
  );

  piso4 #(.MSB_FIRST(0)) dut_l (
    .Clk(Clk), .Rst(Rst), .D(D), .En(En),
    .Ack(ack_l), .Q(q_l), .Qv(qv_l), .Busy(busy_l), .Done(done_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (qv_m) begin
      if (exp_m.size() == 0) chk("msb_unexpected_bit", 4'd1, 4'd0);
      else begin
        e = exp_m.pop_front();
        chk("msb_bit {q,ack,done,busy}", {q_m, ack_m, done_m, busy_m}, {e.q, e.ack, e.done, 1'b1});
      end
    end else begin
      chk("msb_idle {q,ack,done,busy}", {q_m, ack_m, done_m, busy_m}, 4'd0);
    end
    if (ack_m) ack_cyc_m.push_back(cyc);
  end

  always @(negedge Clk) begin
    exp_t e;
    if (qv_l) begin
      if (exp_l.size() == 0) chk("lsb_unexpected_bit", 4'd1, 4'd0);
      else begin
        e = exp_l.pop_front();
        chk("lsb_bit {q,ack,done,busy}", {q_l, ack_l, done_l, busy_l}, {e.q, e.ack, e.done, 1'b1});
      end
    end else begin
      chk("lsb_idle {q,ack,done,busy}", {q_l, ack_l, done_l, busy_l}, 4'd0);
    end
    if (ack_l) ack_cyc_l.push_back(cyc);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // em/el: expected serial order, bit 4 first; bit 0 is the parity bit when present.
  task automatic push_exp(input logic [4:0] em, input logic [4:0] el, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.ack  = (i == 0);
      e.done = (i == N - 1);
      e.q    = em[4 - i];
      exp_m.push_back(e);
      e.q    = el[4 - i];
      exp_l.push_back(e);
    end
  endtask

  task automatic send(input logic [3:0] d, input logic [4:0] em, input logic [4:0] el);
    push_exp(em, el, N);
    D  = d;
    En = 1'b1;
    tick();
    En = 1'b0;
    repeat (N + 1) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_msb"}, {q_m, qv_m, ack_m, busy_m | done_m}, 4'd0);
    chk({name, "_lsb"}, {q_l, qv_l, ack_l, busy_l | done_l}, 4'd0);
  endtask

  initial begin
    int base_m, base_l;
    Rst = 1'b1;
    En  = 1'b0;
    D   = 4'd0;
    repeat (3) tick();
    chk_all_zero("reset_state");
    Rst = 1'b0;
    tick();

    send(4'b1010, 5'b10100, 5'b01010);
    send(4'b0110, 5'b01100, 5'b01100);

    // En held through the whole word with a different D: ignored, word unchanged
    base_m = ack_cyc_m.size();
    push_exp(5'b11000, 5'b00110, N);
    D  = 4'b1100;
    En = 1'b1;
    tick();
    D  = 4'b0011;
    repeat (N) tick();
    En = 1'b0;
    repeat (2) tick();
    chk("en_in_shift_ack_count", 4'(ack_cyc_m.size() - base_m), 4'd1);

    // reset on the third bit aborts the word
    push_exp(5'b11110, 5'b11110, 3);
    for (int i = 0; i < 3; i++) exp_m[exp_m.size() - 1 - i].done = 1'b0;
    for (int i = 0; i < 3; i++) exp_l[exp_l.size() - 1 - i].done = 1'b0;
    D  = 4'b1111;
    En = 1'b1;
    tick();
    En = 1'b0;
    repeat (2) tick();
    Rst = 1'b1;
    tick();
    chk_all_zero("abort_reset");
    chk("abort_queue_drained", 4'(exp_m.size() + exp_l.size()), 4'd0);
    base_m = ack_cyc_m.size();
    En = 1'b1;
    tick();
    chk_all_zero("rst_over_en");
    Rst = 1'b0;
    En  = 1'b0;
    tick();
    chk("rst_over_en_no_ack", 4'(ack_cyc_m.size() - base_m), 4'd0);
    send(4'b0101, 5'b01010, 5'b10100);

    // En held high: back-to-back words with one idle cycle between them
    base_m = ack_cyc_m.size();
    base_l = ack_cyc_l.size();
    push_exp(5'b10010, 5'b10010, N);
    push_exp(5'b10010, 5'b10010, N);
    D  = 4'b1001;
    En = 1'b1;
    repeat (N + 2) tick();
    En = 1'b0;
    repeat (N + 1) tick();
    chk("held_en_ack_count", 4'(ack_cyc_m.size() - base_m), 4'd2);
    if (ack_cyc_m.size() >= base_m + 2)
      chk("held_en_ack_spacing_msb", 4'(ack_cyc_m[base_m + 1] - ack_cyc_m[base_m]), 4'(N + 1));
    if (ack_cyc_l.size() >= base_l + 2)
      chk("held_en_ack_spacing_lsb", 4'(ack_cyc_l[base_l + 1] - ack_cyc_l[base_l]), 4'(N + 1));

`ifdef PISO4_PARITY_EN
    send(4'b0111, 5'b01111, 5'b11101);
`endif

    repeat (2) tick();
    chk("final_queue_msb_empty", 4'(exp_m.size()), 4'd0);
    chk("final_queue_lsb_empty", 4'(exp_l.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
